hazard_fwd_pipe: RTL
====================

Name: hazard_fwd_pipe

Overview:
- Parametrised hazard/forwarding unit for the MIPS pipeline; next generation of the ID-stage control unit's hazard logic.
- Keeps its own shadow pipeline of destination-register records for the NSTG stages after ID (EX, MEM, WB, ...).
- Drives per-operand forwarding selects and the IF/ID stall.
- Supports any depth, configurable load-use latency, and a no-forwarding mode.
- Keeps a saturating stall-cycle counter.

Parameters:
- NSTG, 3: stages tracked after ID; stage 1 = EX, stage NSTG = WB.
- LOAD_LAT, 2: first stage index at which load data can be forwarded (2 = MEM output). Range 1..NSTG.
- FWD_EN, 1: 1 = forwarding enabled; 0 = stall on every RAW hazard until the producer has retired.
- RBITS, 5: register index width.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  RBITS  source A index.
- id_rt  in  RBITS  source B index.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_dst  in  RBITS  destination index (rd or rt, already muxed).
- id_wreg  in  1  instruction writes a register.
- id_load  in  1  instruction is a load.
- flush  in  1  squash the ID instruction (taken branch/jump resolved in ID).
- stall  out  1  hold PC and IF/ID, inject bubble into EX.
- fwd_a  out  FW  operand A select, FW = $clog2(NSTG+1); 0 = register file, k = result of stage k.
- fwd_b  out  FW  operand B select, same encoding.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Shadow entry s[k], k = 1..NSTG, fields {v, wreg, load, dst}. An entry is a producer when v & wreg & dst != 0.
- avail(k) = LOAD_LAT if s[k].load, else 1.
- Source match for rs: the instruction is id_valid & id_use_rs & id_rs != 0. Choose the youngest producer, i.e. the smallest k with s[k].dst == id_rs. Same rule for rt.
- FWD_EN = 1, per operand:
  - No match: fwd = 0, no hazard.
  - Match at k with k >= avail(k): fwd = k.
  - Match with k < avail(k): hazard, fwd = 0.
- FWD_EN = 0: any match is a hazard; fwd_a and fwd_b are held at 0.
- Register file is write-before-read, so an entry that has left stage NSTG never matches.
- stall = (hazard_a | hazard_b) & ~flush. Purely combinational, same cycle.
- flush has priority: the squashed instruction causes no stall, and its entry enters EX as a bubble.
- Shift on every rising clk:
  - s[k+1] <= s[k] for k = 1..NSTG-1; s[NSTG] is discarded.
  - s[1] <= bubble (v = 0) if stall | flush | ~id_valid; otherwise {1, id_wreg, id_load, id_dst}.
  - There is no downstream back-pressure; stages always advance.
- stall_cnt increments on each cycle with stall = 1 and saturates at all-ones. It never wraps.
- Reset (rst = 0, asynchronous): all s[k].v = 0 and stall_cnt = 0. As a result stall = 0 and fwd_a = fwd_b = 0 for any inputs while reset is held and in the first cycle after.
- Reset asserted mid-stall clears the tracked hazards immediately; the stall drops in the same cycle.
- Latency: a hazard with ALU producer at stage 1 (LOAD_LAT N/A) forwards with 0 stall cycles.
- A load producer stalls LOAD_LAT-1 cycles, then forwards from stage LOAD_LAT.
- With FWD_EN = 0, a producer at stage k causes NSTG-k+1 stall cycles.
- If rs == rt and both are used, both selects are identical.
- A producer with dst = 0 is never matched.

Decomposition:
- Shared package (hazard_pkg):
  - FWD_RF = 0 constant.
  - Shadow-entry struct {v, wreg, load, dst}.
  - Function fwd_width(NSTG).
- One natural sub-module: hz_src_match, instantiated twice (rs, rt). It is a priority search across the NSTG entries and returns {hazard, fwd_sel}.
- The shift register and counter live in the top level.

Test Plan:
- Defaults. `add $3,$1,$2` followed by `sub $4,$3,$5` -> stall = 0, fwd_a = 1. Next cycle, an unrelated instruction reading $3 -> fwd = 2.
- Defaults. `lw $3,0($1)` followed by `add $4,$3,$3` -> cycle 1: stall = 1, stall_cnt 0 -> 1, EX gets a bubble. Cycle 2: stall = 0, fwd_a = fwd_b = 2.
- Dual producers: `add $3` at stage 2 and `or $3` at stage 1, consumer reads $3 -> fwd_a = 1 (youngest wins). Destination $0 producer with consumer reading $0 -> fwd = 0, no stall.
- Load-use hazard with flush = 1 in the same cycle -> stall = 0, and s[1].v = 0 next cycle.
- FWD_EN = 0, NSTG = 4, ALU producer of $7 directly ahead of a consumer of $7 -> stall for 4 cycles, then fwd = 0 and the instruction proceeds. stall_cnt = 4.
- CNT_W = 2, hold a hazard 5 cycles -> stall_cnt saturates at 3. Drive rst low mid-stall -> stall = 0 and stall_cnt = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the hazard/forwarding unit.
//   FWD_RF        : forwarding-select value meaning "use the register file".
//   DST_MAX       : storage width of a register index inside a shadow entry.
//                   Register indices (RBITS) up to this width are supported;
//                   narrower indices are zero-extended.
//   shadow_entry_t: one destination record travelling down the pipeline.
//   fwd_width()   : width of a forwarding select for a given depth.
package hazard_pkg;

  localparam int FWD_RF  = 0;
  localparam int DST_MAX = 16;

  typedef struct packed {
    logic               v;
    logic               wreg;
    logic               load;
    logic [DST_MAX-1:0] dst;
  } shadow_entry_t;

  // Select must encode 0 (register file) and 1..nstg (stage results).
  function automatic int fwd_width(input int nstg);
    return (nstg < 1) ? 1 : $clog2(nstg + 1);
  endfunction

endpackage

// File: rtl/hz_src_match.sv
// hz_src_match
//   Priority search of one source operand against the shadow pipeline.
//   Ports:
//     id_valid : ID holds a real instruction
//     use_src  : instruction reads this operand
//     src      : source register index
//     ent      : shadow entries, ent[0] = EX (stage 1) ... ent[NSTG-1] = stage NSTG
//     hazard   : operand value is not yet obtainable, ID must stall
//     fwd_sel  : 0 = register file, k = result of stage k
module hz_src_match
  import hazard_pkg::*;
#(
  parameter int NSTG     = 3,
  parameter int LOAD_LAT = 2,
  parameter int FWD_EN   = 1,
  parameter int RBITS    = 5,
  parameter int FW       = fwd_width(NSTG)
) (
  input  logic             id_valid,
  input  logic             use_src,
  input  logic [RBITS-1:0] src,
  input  shadow_entry_t    ent [NSTG],
  output logic             hazard,
  output logic [FW-1:0]    fwd_sel
);

  logic          hit;
  logic          hit_load;
  logic [FW-1:0] hit_stg;
  logic          src_live;

  // $0 is hard-wired, so neither a $0 reader nor a $0 writer ever matches.
  assign src_live = id_valid & use_src & (src != '0);

  always_comb begin
    hit      = 1'b0;
    hit_load = 1'b0;
    hit_stg  = '0;
    // Scan oldest to youngest so the youngest producer is the last to win.
    for (int i = NSTG - 1; i >= 0; i--) begin
      if (ent[i].v && ent[i].wreg && (ent[i].dst != '0) &&
          (ent[i].dst == DST_MAX'(src))) begin
        hit      = 1'b1;
        hit_load = ent[i].load;
        hit_stg  = FW'(i + 1);
      end
    end
  end

  always_comb begin
    hazard  = 1'b0;
    fwd_sel = FW'(FWD_RF);
    if (src_live && hit) begin
      if (FWD_EN == 0) begin
        // Without bypass paths the value is usable only after retirement.
        hazard = 1'b1;
      end else if (int'(hit_stg) < (hit_load ? LOAD_LAT : 1)) begin
        hazard = 1'b1;
      end else begin
        fwd_sel = hit_stg;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_pipe.sv
// hazard_fwd_pipe
//   Hazard detection and forwarding control for the ID stage. Tracks the
//   destination records of the NSTG instructions downstream of ID and
//   derives per-operand forwarding selects plus the IF/ID stall.
//   Ports:
//     clk, rst        : rising-edge clock, asynchronous active-low reset
//     id_valid        : ID holds a real instruction
//     id_rs, id_rt    : source indices; id_use_rs/id_use_rt say which are read
//     id_dst          : destination index; id_wreg = writes it; id_load = load
//     flush           : squash the ID instruction (no stall, bubble into EX)
//     stall           : hold PC and IF/ID, inject a bubble into EX
//     fwd_a, fwd_b    : operand selects, 0 = register file, k = stage k result
//     stall_cnt       : saturating count of stalled cycles
//   Handshake: none; the shadow pipeline advances on every clock and the
//   stall is a same-cycle combinational output.
module hazard_fwd_pipe
  import hazard_pkg::*;
#(
  parameter int NSTG     = 3,
  parameter int LOAD_LAT = 2,
  parameter int FWD_EN   = 1,
  parameter int RBITS    = 5,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [RBITS-1:0]           id_rs,
  input  logic [RBITS-1:0]           id_rt,
  input  logic                       id_use_rs,
  input  logic                       id_use_rt,
  input  logic [RBITS-1:0]           id_dst,
  input  logic                       id_wreg,
  input  logic                       id_load,
  input  logic                       flush,
  output logic                       stall,
  output logic [fwd_width(NSTG)-1:0] fwd_a,
  output logic [fwd_width(NSTG)-1:0] fwd_b,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int FW = fwd_width(NSTG);

  // s[0] = EX (stage 1) ... s[NSTG-1] = stage NSTG (WB by default).
  shadow_entry_t s [NSTG];
  shadow_entry_t id_ent;
  logic          hazard_a;
  logic          hazard_b;

  hz_src_match #(
    .NSTG(NSTG), .LOAD_LAT(LOAD_LAT), .FWD_EN(FWD_EN), .RBITS(RBITS), .FW(FW)
  ) u_match_a (
    .id_valid (id_valid),
    .use_src  (id_use_rs),
    .src      (id_rs),
    .ent      (s),
    .hazard   (hazard_a),
    .fwd_sel  (fwd_a)
  );

  hz_src_match #(
    .NSTG(NSTG), .LOAD_LAT(LOAD_LAT), .FWD_EN(FWD_EN), .RBITS(RBITS), .FW(FW)
  ) u_match_b (
    .id_valid (id_valid),
    .use_src  (id_use_rt),
    .src      (id_rt),
    .ent      (s),
    .hazard   (hazard_b),
    .fwd_sel  (fwd_b)
  );

  // A squashed instruction never stalls; it simply becomes a bubble.
  assign stall = (hazard_a | hazard_b) & ~flush;

  always_comb begin
    id_ent = '0;
    if (id_valid && !stall && !flush) begin
      id_ent.v    = 1'b1;
      id_ent.wreg = id_wreg;
      id_ent.load = id_load;
      id_ent.dst  = DST_MAX'(id_dst);
    end
  end

  // Shadow pipeline: no back-pressure, every stage advances each cycle and
  // the record leaving stage NSTG is dropped (register file is write-first).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSTG; i++) begin
        s[i] <= '0;
      end
    end else begin
      s[0] <= id_ent;
      for (int i = 1; i < NSTG; i++) begin
        s[i] <= s[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
